// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: FSM state
// encoding, opcode field position and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB       = 31;
  localparam int unsigned OPCODE_LSB       = 26;
  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Watchdog counter for outstanding fetch requests. Counts REQ cycles in
// which memory has not answered; 'expired' flags the cycle whose count
// step would reach LIMIT, so the request is abandoned after exactly LIMIT
// unanswered cycles. Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  // Wait-cycle counter: cleared outside REQ, steps on each unanswered cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + CNT_W'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign expired = count_en && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: owns PC and instruction register, issues
// word reads over a req/ready handshake and pulses instr_valid when a new
// instruction is latched. Optional request watchdog: FETCH_TIMEOUT_EN.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned INSTR_W        = 32,
  parameter int unsigned RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_start,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_target,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_busy,
  output logic               fetch_err
);

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_d;
  logic [INSTR_W-1:0]  instr_q;
  logic                instr_valid_q;
  logic                mem_req_q;
  logic                fetch_busy_q;
  logic                fetch_err_q;
  logic                handshake_s;
  logic                timeout_expired_s;

  assign handshake_s = (state_q == ST_REQ) && mem_ready;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q != ST_REQ),
    .count_en ((state_q == ST_REQ) && !mem_ready),
    .expired  (timeout_expired_s)
  );
`else
  // Watchdog compiled out: a request waits for memory indefinitely.
  assign timeout_expired_s = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Next PC: a redirect beats the post-fetch increment; max address wraps.
  always_comb begin
    pc_d = pc_q;
    if (pc_load) begin
      pc_d = pc_target;
    end else if (handshake_s) begin
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch FSM with registered handshake/status outputs and PC/IR update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
      fetch_busy_q  <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (fetch_start) begin
            state_q      <= ST_REQ;
            mem_req_q    <= 1'b1;
            fetch_busy_q <= 1'b1;
          end else begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            fetch_busy_q <= 1'b0;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            instr_q       <= mem_rdata;
            instr_valid_q <= 1'b1;
            state_q       <= ST_DONE;
            mem_req_q     <= 1'b0;
            fetch_busy_q  <= 1'b0;
          end else if (timeout_expired_s) begin
            // Abandon the request; instr and pc are left untouched.
            fetch_err_q  <= 1'b1;
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            fetch_busy_q <= 1'b0;
          end else begin
            state_q <= ST_REQ;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          mem_req_q    <= 1'b0;
          fetch_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid = instr_valid_q;
  assign fetch_busy  = fetch_busy_q;
  assign fetch_err   = fetch_err_q;

endmodule
